// File: rtl/cfg_discovery_rsp.sv
// Read-only responder returning integrator-packed 32-bit configuration words as single or burst reads.
// Optional `CFG_DISCOVERY_PARITY_EN adds rsp_parity_o, even parity over {rsp_err_o, rsp_data_o}.
module cfg_discovery_rsp #(
  parameter int NrWords   = 64,
  parameter int AddrWidth = 8,
  parameter int LenWidth  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NrWords*32-1:0]  cfg_words_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [LenWidth-1:0]    req_len_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   rsp_last_o
`ifdef CFG_DISCOVERY_PARITY_EN
  ,
  output logic                   rsp_parity_o
`endif
);

  typedef enum logic {IDLE, RESP} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth:0]   addr_q, addr_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic                 load, clear, load_last;
  logic [AddrWidth:0]   load_addr;
  logic [32:0]          beat;

  logic [31:0]          data_p1;
  logic                 err_p1;
  logic                 last_p1;

  // Index beyond the table (including beyond 2^AddrWidth) yields err=1 with zero data.
  function automatic logic [32:0] fetch_beat(input logic [NrWords*32-1:0] tbl,
                                             input logic [AddrWidth:0]    idx);
    int i;
    i = int'(idx);
    if (i < NrWords) return {1'b0, tbl[i*32 +: 32]};
    return {1'b1, 32'd0};
  endfunction

  function automatic logic even_parity(input logic err, input logic [31:0] data);
    return ^{err, data};
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    load        = 1'b0;
    clear       = 1'b0;
    load_last   = 1'b0;
    load_addr   = addr_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = ~rst_i;
        if (req_valid_i && req_ready_o) begin
          addr_d    = {1'b0, req_addr_i};
          rem_d     = req_len_i;
          load      = 1'b1;
          load_addr = {1'b0, req_addr_i};
          load_last = (req_len_i == '0);
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          if (rem_q != '0) begin
            addr_d    = addr_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            load      = 1'b1;
            load_addr = addr_q + 1'b1;
            load_last = (rem_q == LenWidth'(1));
          end else begin
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat = fetch_beat(cfg_words_i, load_addr);

  // Stage p1: registered response beat, held while the initiator stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      if (load) begin
        data_p1 <= beat[31:0];
        err_p1  <= beat[32];
        last_p1 <= load_last;
      end else if (clear) begin
        data_p1 <= '0;
        err_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign rsp_data_o = data_p1;
  assign rsp_err_o  = err_p1;
  assign rsp_last_o = last_p1;

`ifdef CFG_DISCOVERY_PARITY_EN
  logic par_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_p1 <= 1'b0;
    end else if (load) begin
      par_p1 <= even_parity(beat[32], beat[31:0]);
    end else if (clear) begin
      par_p1 <= 1'b0;
    end
  end

  assign rsp_parity_o = par_p1;
`endif

endmodule
